// File: rtl/unified_memory_arbiter_if.sv
// Request/response bundle between the IF/MEM stages, the arbiter and the unified memory.
// The master side is the pipeline plus memory model; the slave side is the arbiter.
interface unified_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  IFReq;
    logic [ADDR_WIDTH-1:0] IFAddr;
    logic                  MemRead;
    logic                  MemWrite;
    logic [ADDR_WIDTH-1:0] DataAddr;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [DATA_WIDTH-1:0] IFReadData;
    logic                  IFValid;
    logic [DATA_WIDTH-1:0] DataReadData;
    logic                  DataValid;
    logic                  StallIF;
    logic                  StallMEM;
    logic [ADDR_WIDTH-1:0] Mem_Addr;
    logic                  Mem_En;
    logic                  Mem_WE;
    logic [DATA_WIDTH-1:0] Mem_WData;
    logic [DATA_WIDTH-1:0] Mem_RData;

    modport master (
        output IFReq, IFAddr, MemRead, MemWrite, DataAddr, WriteData, Mem_RData,
        input  IFReadData, IFValid, DataReadData, DataValid, StallIF, StallMEM,
               Mem_Addr, Mem_En, Mem_WE, Mem_WData
    );

    modport slave (
        input  IFReq, IFAddr, MemRead, MemWrite, DataAddr, WriteData, Mem_RData,
        output IFReadData, IFValid, DataReadData, DataValid, StallIF, StallMEM,
               Mem_Addr, Mem_En, Mem_WE, Mem_WData
    );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Arbitrates one single-port memory between fetch and data; Valid arrives LATENCY+1 cycles after grant decision.
// No queueing: requesters hold their request and see StallIF/StallMEM until their Valid cycle.
module unified_memory_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 2
) (
    input logic                    clk,
    input logic                    reset,
    unified_memory_arbiter_if.slave bus
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] CNT_LAST   = CW'(LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, next_state;
    logic                  grant_d;
    logic                  is_write;
    logic [CW-1:0]         cnt;
    logic [SW-1:0]         starve;
    logic [DATA_WIDTH-1:0] if_rdata, d_rdata, mem_wdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  if_valid, d_valid, mem_en, mem_we;
    logic                  dreq, pick_d, pick_i, last;

    assign dreq   = bus.MemRead | bus.MemWrite;
    // Data wins unless fetch has already waited out STARVE_LIMIT data grants.
    assign pick_d = dreq & (~bus.IFReq | (starve < STARVE_MAX));
    assign pick_i = ~pick_d & bus.IFReq;
    assign last   = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_d | pick_i) next_state = ACCESS;
            ACCESS:  if (last) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_d   <= 1'b0;
            is_write  <= 1'b0;
            cnt       <= '0;
            starve    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d | pick_i) begin
                        grant_d   <= pick_d;
                        is_write  <= pick_d & bus.MemWrite;
                        mem_we    <= pick_d & bus.MemWrite;
                        mem_en    <= 1'b1;
                        mem_addr  <= pick_d ? bus.DataAddr : bus.IFAddr;
                        mem_wdata <= bus.WriteData;
                        cnt       <= '0;
                        if (pick_d && bus.IFReq)
                            starve <= (starve == STARVE_MAX) ? starve : starve + SW'(1);
                        else
                            starve <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        mem_en <= 1'b0;
                        if (grant_d) begin
                            d_valid <= 1'b1;
                            if (!is_write) d_rdata <= bus.Mem_RData;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= bus.Mem_RData;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.StallIF      = bus.IFReq & ~((state == RESP) & ~grant_d);
    assign bus.StallMEM     = dreq & ~((state == RESP) & grant_d);
    assign bus.IFReadData   = if_rdata;
    assign bus.IFValid      = if_valid;
    assign bus.DataReadData = d_rdata;
    assign bus.DataValid    = d_valid;
    assign bus.Mem_Addr     = mem_addr;
    assign bus.Mem_En       = mem_en;
    assign bus.Mem_WE       = mem_we;
    assign bus.Mem_WData    = mem_wdata;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Scoreboarded bench for unified_memory_arbiter with a behavioural single-port memory.
module tb_unified_memory_arbiter;
    localparam int DW = 32, AW = 32, LAT = 2, SL = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    unified_memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    unified_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT), .STARVE_LIMIT(SL))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0, errors = 0;
    int cyc = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_if[$], exp_d[$];
    bit          gnt_log[$];
    logic [31:0] last_dread = 0;
    logic [31:0] wr_addr_exp, wr_data_exp;
    int we_cnt = 0, stallif_cnt = 0, if_vld_cnt = 0, d_vld_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.Mem_En && bus.Mem_WE) mem[bus.Mem_Addr] = bus.Mem_WData;
    end

    always @(negedge clk) bus.Mem_RData = rd(bus.Mem_Addr);

    always @(negedge clk) if (reset) begin
        if (bus.StallIF) stallif_cnt++;
        if (bus.Mem_WE) begin
            we_cnt++;
            check("we_addr", bus.Mem_Addr, wr_addr_exp);
            check("we_data", bus.Mem_WData, wr_data_exp);
        end
        if (bus.IFValid) begin
            if_vld_cnt++;
            gnt_log.push_back(1'b0);
            check("stallif_at_valid", bus.StallIF, 0);
            if (exp_if.size() == 0) check("if_unexpected", 1, 0);
            else check("if_data", bus.IFReadData, exp_if.pop_front());
        end
        if (bus.DataValid) begin
            d_vld_cnt++;
            gnt_log.push_back(1'b1);
            check("stallmem_at_valid", bus.StallMEM, 0);
            if (exp_d.size() == 0) check("d_unexpected", 1, 0);
            else check("d_data", bus.DataReadData, exp_d.pop_front());
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input bit want_d, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (want_d ? bus.DataValid : bus.IFValid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check(want_d ? "timeout_d" : "timeout_i", 0, 1);
        step();
    endtask

    task automatic push_read(input logic [31:0] a);
        last_dread = rd(a);
        exp_d.push_back(last_dread);
    endtask

    int t0, ai, ad, vcnt;
    bit exp_order [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        bus.IFReq = 0; bus.IFAddr = 0; bus.MemRead = 0; bus.MemWrite = 0;
        bus.DataAddr = 0; bus.WriteData = 0;
        mem[32'h0040_0000] = 32'h2008_0005;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ifvalid", bus.IFValid, 0);
        check("rst_dvalid", bus.DataValid, 0);
        check("rst_mem_en", bus.Mem_En, 0);
        check("rst_mem_we", bus.Mem_WE, 0);
        check("rst_mem_addr", bus.Mem_Addr, 0);
        check("rst_ifrdata", bus.IFReadData, 0);
        check("rst_drdata", bus.DataReadData, 0);
        check("rst_stallif", bus.StallIF, 0);
        step();
        reset = 1;
        step();

        // single fetch
        bus.IFReq = 1; bus.IFAddr = 32'h0040_0000; t0 = cyc; stallif_cnt = 0;
        exp_if.push_back(32'h2008_0005);
        @(negedge clk);
        check("t1_en_t0", bus.Mem_En, 0);
        check("t1_stall_t0", bus.StallIF, 1);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("t1_en_acc", bus.Mem_En, 1);
            check("t1_addr_acc", bus.Mem_Addr, 32'h0040_0000);
        end
        @(negedge clk);
        check("t1_ifvalid", bus.IFValid, 1);
        check("t1_valid_cyc", cyc - t0, LAT + 1);
        check("t1_en_resp", bus.Mem_En, 0);
        check("t1_stall_cnt", stallif_cnt, 3);
        step();
        bus.IFReq = 0;
        step();

        // simultaneous fetch and load: data first
        bus.IFReq = 1; bus.IFAddr = 32'h0040_0008;
        bus.MemRead = 1; bus.DataAddr = 32'h1001_0000;
        push_read(32'h1001_0000); exp_if.push_back(rd(32'h0040_0008));
        t0 = cyc; stallif_cnt = 0;
        wait_valid(1, 20, ad);
        check("t2_d_cyc", ad - t0, 3);
        bus.MemRead = 0;
        wait_valid(0, 20, ai);
        check("t2_i_cyc", ai - t0, 7);
        check("t2_stall_cnt", stallif_cnt, 7);
        bus.IFReq = 0;
        step();

        // starvation bound
        gnt_log.delete();
        bus.IFReq = 1; bus.IFAddr = 32'h0040_0010;
        bus.MemRead = 1; bus.DataAddr = 32'h1001_0010;
        for (int k = 0; k < 4; k++) push_read(32'h1001_0010);
        for (int k = 0; k < 2; k++) exp_if.push_back(rd(32'h0040_0010));
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (gnt_log.size() >= 6) break;
        end
        #1;
        bus.IFReq = 0; bus.MemRead = 0;
        check("t3_grants", gnt_log.size(), 6);
        for (int k = 0; k < 6 && k < gnt_log.size(); k++)
            check($sformatf("t3_order%0d", k), gnt_log[k], exp_order[k]);
        step();

        // store, with inputs changing after grant
        we_cnt = 0; wr_addr_exp = 32'h1001_0004; wr_data_exp = 32'hDEAD_BEEF;
        bus.MemWrite = 1; bus.DataAddr = 32'h1001_0004; bus.WriteData = 32'hDEAD_BEEF;
        exp_d.push_back(last_dread);
        t0 = cyc;
        step();
        bus.DataAddr = 32'h0000_0BAD; bus.WriteData = 32'h0;
        wait_valid(1, 20, ad);
        check("t4_d_cyc", ad - t0, 3);
        check("t4_we_cnt", we_cnt, 1);
        check("t4_mem", rd(32'h1001_0004), 32'hDEAD_BEEF);
        bus.MemWrite = 0;
        step();
        bus.MemRead = 1; bus.DataAddr = 32'h1001_0004;
        push_read(32'h1001_0004);
        wait_valid(1, 20, ad);
        bus.MemRead = 0;
        step();

        // reset during second access cycle
        bus.IFReq = 1; bus.IFAddr = 32'h0040_0020;
        exp_if.push_back(rd(32'h0040_0020));
        vcnt = if_vld_cnt;
        step(); step();
        reset = 0;
        #1;
        check("t5_en", bus.Mem_En, 0);
        check("t5_addr", bus.Mem_Addr, 0);
        check("t5_ifrdata", bus.IFReadData, 0);
        check("t5_drdata", bus.DataReadData, 0);
        check("t5_stallif", bus.StallIF, 1);
        @(negedge clk);
        check("t5_no_valid", bus.IFValid, 0);
        step();
        reset = 1; last_dread = 0; t0 = cyc;
        wait_valid(0, 20, ai);
        check("t5_restart_cyc", ai - t0, 3);
        check("t5_one_valid", if_vld_cnt, vcnt + 1);
        bus.IFReq = 0;
        step();

        // read+write = write; fetch dropped mid-access
        we_cnt = 0; wr_addr_exp = 32'h1001_0008; wr_data_exp = 32'h1234_5678;
        bus.MemRead = 1; bus.MemWrite = 1; bus.DataAddr = 32'h1001_0008; bus.WriteData = 32'h1234_5678;
        bus.IFReq = 1; bus.IFAddr = 32'h0040_0030;
        exp_d.push_back(last_dread); exp_if.push_back(rd(32'h0040_0030));
        wait_valid(1, 20, ad);
        bus.MemRead = 0; bus.MemWrite = 0;
        check("t6_we_cnt", we_cnt, 1);
        check("t6_mem", rd(32'h1001_0008), 32'h1234_5678);
        step();
        bus.IFReq = 0;
        vcnt = if_vld_cnt;
        wait_valid(0, 20, ai);
        check("t6_drop_valid", if_vld_cnt, vcnt + 1);
        repeat (5) step();
        check("t6_no_extra", if_vld_cnt, vcnt + 1);
        check("t6_idle_en", bus.Mem_En, 0);
        check("t6_stallif", bus.StallIF, 0);
        check("sb_if_empty", exp_if.size(), 0);
        check("sb_d_empty", exp_d.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unified_memory_arbiter.md
Name: unified_memory_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) stage and the data-access (MEM) stage.
- The MEM stage issues lw/sw requests using the MemRead/MemWrite flags that the control unit generates.
- The block sequences each fixed-latency memory access, arbitrates between the two requesters, and drives per-stage stall signals to the hazard/pipeline-register logic.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
DATA_WIDTH, 32, memory word width
ADDR_WIDTH, 32, byte address width
LATENCY, 2, memory cycles per access (>=1)
STARVE_LIMIT, 2, consecutive data grants allowed while IFReq is pending before IF is forced

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
IFReq  in  1  fetch request; held until IFValid
IFAddr  in  ADDR_WIDTH  fetch address (PC)
MemRead  in  1  data read request (lw)
MemWrite  in  1  data write request (sw)
DataAddr  in  ADDR_WIDTH  data address (ALU result)
WriteData  in  DATA_WIDTH  store data
IFReadData  out  DATA_WIDTH  fetched instruction, registered
IFValid  out  1  one-cycle fetch completion pulse
DataReadData  out  DATA_WIDTH  load data, registered
DataValid  out  1  one-cycle data completion pulse (reads and writes)
StallIF  out  1  freeze PC and IF/ID register
StallMEM  out  1  freeze all stages up to and including EX/MEM
Mem_Addr  out  ADDR_WIDTH  memory address
Mem_En  out  1  access enable
Mem_WE  out  1  write strobe
Mem_WData  out  DATA_WIDTH  memory write data
Mem_RData  in  DATA_WIDTH  memory read data; valid on the LATENCY-th ACCESS cycle

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; grant, counters and starve count cleared.
  - All registered outputs 0: IFReadData, DataReadData, IFValid, DataValid, Mem_*.
  - Stall outputs follow their combinational equations from IDLE.
- Data request: DReq = MemRead|MemWrite. If both flags are set, the access is a write.
- FSM states: IDLE, ACCESS, RESP.
- IDLE arbitration:
  - DReq and (not IFReq or starve<STARVE_LIMIT) -> grant D.
  - Else IFReq -> grant I.
  - Else stay in IDLE.
- On a grant:
  - Latch address, wdata and is_write into registers; cnt<=0; go to ACCESS.
  - Starve count: +1 on a D grant while IFReq=1; cleared on an I grant, or on a D grant with IFReq=0; saturates at STARVE_LIMIT.
- ACCESS:
  - Mem_En=1 and Mem_Addr=latched address.
  - Mem_WE=1 only in the first ACCESS cycle of a write. Mem_WData=latched data.
  - cnt increments each cycle.
  - When cnt==LATENCY-1: capture Mem_RData into IFReadData (grant I) or DataReadData (grant D read); leave DataReadData unchanged on writes. Go to RESP.
- RESP:
  - IFValid or DataValid=1 for exactly this cycle; Mem_En=0.
  - Next state is always IDLE; no back-to-back grant.
- Latency: a request first seen in IDLE at cycle t gives Valid at cycle t+LATENCY+1. A waiting requester adds the full in-flight access.
- Stalls (combinational):
  - StallIF = IFReq & ~(state==RESP & grant==I).
  - StallMEM = DReq & ~(state==RESP & grant==D).
  - A stall deasserts in the same cycle as the matching Valid.
- Request dropped mid-access (e.g. pipeline flush):
  - The access still completes and the Valid pulse is still issued.
  - A write is never aborted once Mem_WE has fired.
- Requests arriving during ACCESS/RESP are queued only by being held; they are sampled in the next IDLE cycle.
- Read data registers hold their value until the next capture for that requester.
- Address and data changes on the inputs after a grant are ignored.

Test Plan:
- LATENCY=2, IFReq=1 with IFAddr=0x00400000 at t0, Mem_RData=0x20080005 -> Mem_En at t1–t2, IFValid and IFReadData=0x20080005 at t3, StallIF=1 at t0–t2 and 0 at t3.
- IFReq and MemRead both rise at t0, DataAddr=0x10010000 -> data served first (DataValid t3), IF served next (IFValid t7); StallIF high t0–t6.
- MemRead held continuously with IFReq=1, STARVE_LIMIT=2 -> grant order D,D,I,D,D,I; IF is never starved.
- MemWrite=1, DataAddr=0x10010004, WriteData=0xDEADBEEF -> Mem_WE=1 for exactly one cycle with matching Mem_Addr/WData, DataValid at t3, DataReadData unchanged.
- reset pulled low during the second ACCESS cycle -> immediately IDLE, all outputs 0, no Valid pulse; after release a pending IFReq restarts its access from scratch.
- MemRead=MemWrite=1 -> treated as a write (Mem_WE pulse); IFReq deasserted mid-access -> IFValid pulse still emitted, then state returns to IDLE.
